bcd_to_bin_seq: RTL and testbench

- Sequential converter from a packed multi-digit BCD word (the format the BCD adder chain produces) to a plain unsigned binary value.
- Lets downstream binary logic consume BCD arithmetic results.
- Processes one digit per clock, most-significant digit first: acc = acc*10 + digit.
- Valid/ready handshake on both input and output; flags any digit greater than 9.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_digit_mac.sv | 23 ++
 rtl/bcd_to_bin_seq.sv | 98 +++++++++
 tb/tb_bcd_to_bin_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit geometry, converter state encoding and
// the BCD-digits-to-binary-width helper used by BCD/binary converters.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } bcd_state_e;

    // Bits needed to hold 10^ndig - 1, i.e. ceil(log2(10^ndig)).
    function automatic int bcd_bin_width(input int ndig);
        longint p = 1;
        int     w = 0;
        for (int i = 0; i < ndig; i++) p = p * 10;
        while ((longint'(1) << w) < p) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// One Horner step of BCD-to-binary conversion: acc*10 + digit, truncated
// to BW bits, with a flag for digits outside 0..9.
module bcd_digit_mac
    import bcd_pkg::*;
#(
    parameter int BW = 14
) (
    input  logic [BW-1:0]          acc,
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BW-1:0]          acc_next,
    output logic                   digit_err
);

    logic [BW-1:0] digit_ext;

    always_comb begin
        digit_ext = BW'(digit);
        // Shift-and-add times ten keeps the step multiplier-free.
        acc_next  = (acc << 3) + (acc << 1) + digit_ext;
        digit_err = (digit > BCD_DIGIT_W'(BCD_MAX));
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first,
// with valid/ready on both sides and a sticky bad-digit flag.
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int BW   = 14
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BCD_DIGIT_W*NDIG-1:0] bcd_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BW-1:0]               bin_out,
    output logic                        err
);

    // Handshake: a transfer happens on a rising edge where valid and ready
    // are both high; ready never depends combinationally on valid.
    localparam int SW = BCD_DIGIT_W * NDIG;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

    bcd_state_e state;
    logic [SW-1:0] sr;
    logic [BW-1:0] acc;
    logic [CW-1:0] cnt;
    logic          err_int;

    logic [BCD_DIGIT_W-1:0] msd;
    logic [BW-1:0]          acc_next;
    logic                   digit_err;
    logic                   err_next;

    assign msd      = sr[SW-1 -: BCD_DIGIT_W];
    assign err_next = err_int | digit_err;

    bcd_digit_mac #(.BW(BW)) u_mac (
        .acc       (acc),
        .digit     (msd),
        .acc_next  (acc_next),
        .digit_err (digit_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr        <= '0;
            acc       <= '0;
            cnt       <= '0;
            err_int   <= 1'b0;
            bin_out   <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr       <= bcd_in;
                        acc      <= '0;
                        cnt      <= '0;
                        err_int  <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    acc     <= acc_next;
                    sr      <= sr << BCD_DIGIT_W;
                    cnt     <= cnt + 1'b1;
                    err_int <= err_next;
                    if (cnt == CW'(NDIG - 1)) begin
                        // A bad digit anywhere suppresses the value entirely.
                        bin_out   <= err_next ? '0 : acc_next;
                        err       <= err_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed bench for bcd_to_bin_seq (NDIG=4, BW=14): scenario tasks with
// hand-computed expected values and a single summary line.
module tb_bcd_to_bin_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bcd_in;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] bin_out;
    logic        err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    bcd_to_bin_seq #(.NDIG(4), .BW(14)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drive one word for exactly one edge; returns at posedge+1 after accept.
    task automatic send(input logic [15:0] word);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: in_ready=%b required 1 (word %h)", in_ready, word);
        end
        bcd_in   = word;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Waits for out_valid with a cycle budget; reports edges waited.
    task automatic wait_out(input string name, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: out_valid never rose within %0d cycles", name, n);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || bin_out !== 14'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: out_valid=%b bin_out=%0d err=%b required 0/0/0",
                     out_valid, bin_out, err);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        int n;
        out_ready = 1'b1;
        send(16'h1234);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: in_ready=%b required 0", in_ready);
        end
        wait_out("basic", n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL basic_latency: edges=%0d required 4", n);
        end
        checks++;
        if (bin_out !== 14'h04D2 || err !== 1'b0) begin
            errors++;
            $display("FAIL basic_value: bin_out=%0d err=%b required 1234/0", bin_out, err);
        end
        drain();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_return: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_values();
        logic [15:0] words [3];
        logic [13:0] exps  [3];
        int n;
        words = '{16'h9999, 16'h0000, 16'h0001};
        exps  = '{14'd9999, 14'd0, 14'd1};
        for (int i = 0; i < 3; i++) begin
            send(words[i]);
            wait_out("values", n);
            checks++;
            if (bin_out !== exps[i] || err !== 1'b0) begin
                errors++;
                $display("FAIL values_%h: bin_out=%0d err=%b required %0d/0",
                         words[i], bin_out, err, exps[i]);
            end
            drain();
        end
    endtask

    task automatic test_err();
        int n;
        send(16'h12A4);
        wait_out("err", n);
        checks++;
        if (err !== 1'b1 || bin_out !== 14'd0) begin
            errors++;
            $display("FAIL err_flag: err=%b bin_out=%0d required 1/0", err, bin_out);
        end
        drain();
        send(16'h0042);
        wait_out("err_clear", n);
        checks++;
        if (err !== 1'b0 || bin_out !== 14'd42) begin
            errors++;
            $display("FAIL err_clear: err=%b bin_out=%0d required 0/42", err, bin_out);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int n;
        int bad = 0;
        out_ready = 1'b0;
        send(16'h0500);
        wait_out("bp", n);
        bcd_in = 16'h0777;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || bin_out !== 14'd500 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d cycles unstable, required 0 (out_valid=%b bin_out=%0d in_ready=%b)",
                     bad, out_valid, bin_out, in_ready);
        end
        drain();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_once: out_valid seen %0d cycles after drain, required 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int bad = 0;
        out_ready = 1'b1;
        send(16'h4321);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || bin_out !== 14'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_clear: out_valid=%b bin_out=%0d in_ready=%b required 0/0/1",
                     out_valid, bin_out, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midrst_abort: %0d bad cycles after release, required 0", bad);
        end
        send(16'h0010);
        wait_out("midrst_next", n);
        checks++;
        if (bin_out !== 14'd10 || err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_next: bin_out=%0d err=%b required 10/0", bin_out, err);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3];
        logic [13:0] exps  [3];
        int stamp [3];
        int n;
        words = '{16'h0001, 16'h0099, 16'h1000};
        exps  = '{14'd1, 14'd99, 14'd1000};
        out_ready = 1'b1;
        bcd_in    = words[0];
        in_valid  = 1'b1;
        @(posedge clk); #1;
        bcd_in = words[1];
        for (int k = 0; k < 3; k++) begin
            wait_out("b2b", n);
            stamp[k] = cyc;
            checks++;
            if (bin_out !== exps[k] || err !== 1'b0) begin
                errors++;
                $display("FAIL b2b_value%0d: bin_out=%0d err=%b required %0d/0",
                         k, bin_out, err, exps[k]);
            end
            @(posedge clk); #1;
            if (k == 2) in_valid = 1'b0;
            else begin
                @(posedge clk); #1;
                bcd_in = words[(k == 0) ? 2 : 2];
            end
        end
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (stamp[k] - stamp[k-1] != 6) begin
                errors++;
                $display("FAIL b2b_spacing%0d: %0d cycles required 6", k, stamp[k] - stamp[k-1]);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        bcd_in    = '0;
        test_reset();
        test_basic();
        test_values();
        test_err();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
